// File: rtl/mem_arb_rr_if.sv
// Client request bus and byte-wide RAM port of the round-robin memory arbiter.
interface mem_arb_rr_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                       rdy_in;
  logic                       flush_in;
  logic [7:0]                 ram_rdata_in;
  logic [7:0]                 ram_wdata_out;
  logic [ADDR_W-1:0]          ram_addr_out;
  logic                       ram_rw_out;
  logic [NUM_CH-1:0]          req_en_in;
  logic [NUM_CH-1:0]          req_wr_in;
  logic [NUM_CH-1:0]          req_signed_in;
  logic [2*NUM_CH-1:0]        req_size_in;
  logic [ADDR_W*NUM_CH-1:0]   req_addr_in;
  logic [DATA_W*NUM_CH-1:0]   req_wdata_in;
  logic [NUM_CH-1:0]          gnt_out;
  logic [NUM_CH-1:0]          done_out;
  logic [DATA_W-1:0]          rdata_out;

  modport slave (
    input  rdy_in, flush_in, ram_rdata_in,
    input  req_en_in, req_wr_in, req_signed_in, req_size_in, req_addr_in, req_wdata_in,
    output ram_wdata_out, ram_addr_out, ram_rw_out, gnt_out, done_out, rdata_out
  );

  modport master (
    output rdy_in, flush_in, ram_rdata_in,
    output req_en_in, req_wr_in, req_signed_in, req_size_in, req_addr_in, req_wdata_in,
    input  ram_wdata_out, ram_addr_out, ram_rw_out, gnt_out, done_out, rdata_out
  );
endinterface

// File: rtl/mem_arb_rr.sv
// Round-robin arbiter serialising NUM_CH client accesses onto one 8-bit RAM port.
// Reads are sign/zero extended; flush aborts reads but lets a started write finish.
module mem_arb_rr #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  mem_arb_rr_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [1:0] MAX_SZ = 2'($clog2(NB));

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RTAIL = 2'd2} state_t;

  state_t             state_r;
  logic [CH_W-1:0]    rr_ptr_r;
  logic [CH_W-1:0]    ch_r;
  logic [NUM_CH-1:0]  gnt_r;
  logic [NUM_CH-1:0]  done_r;
  logic [DATA_W-1:0]  rdata_r;
  logic               wr_r;
  logic               sgn_r;
  logic [IDX_W-1:0]   last_r;
  logic [IDX_W-1:0]   idx_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic [DATA_W-1:0]  asm_r;

  logic [NUM_CH-1:0]  elig_s;
  logic               found_s;
  logic               hit_s;
  logic [CH_W-1:0]    scan_s;
  logic [CH_W-1:0]    win_s;
  logic [NUM_CH-1:0]  win_onehot_s;
  logic [1:0]         sz_raw_s;
  logic [1:0]         sz_s;
  logic [IDX_W-1:0]   last_s;
  logic [IDX_W-1:0]   cap_idx_s;
  logic [CH_W-1:0]    next_ptr_s;
  logic [DATA_W-1:0]  asm_full_s;
  logic               xfer_s;

  logic [ADDR_W-1:0]  addr_arr_s  [NUM_CH];
  logic [DATA_W-1:0]  wdata_arr_s [NUM_CH];
  logic [1:0]         size_arr_s  [NUM_CH];

  // Extends the assembled read value from the top bit of byte 'last'.
  function automatic logic [DATA_W-1:0] extend_f(input logic [DATA_W-1:0] v,
                                                 input logic [IDX_W-1:0] last,
                                                 input logic sgn);
    logic [DATA_W-1:0] r;
    logic              msb;
    msb = 1'b0;
    for (int j = 0; j < NB; j++) begin
      msb = (j == int'(last)) ? v[8*j+7] : msb;
    end
    for (int j = 0; j < NB; j++) begin
      r[8*j +: 8] = (j <= int'(last)) ? v[8*j +: 8] : {8{sgn & msb}};
    end
    return r;
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign addr_arr_s[c]  = bus.req_addr_in[c*ADDR_W +: ADDR_W];
    assign wdata_arr_s[c] = bus.req_wdata_in[c*DATA_W +: DATA_W];
    assign size_arr_s[c]  = bus.req_size_in[c*2 +: 2];
  end

  // A channel being told done this cycle is not re-granted; flush blocks new reads.
  assign elig_s = bus.req_en_in & ~done_r & (bus.flush_in ? bus.req_wr_in : {NUM_CH{1'b1}});

  // Scan upward from rr_ptr with wrap; first eligible channel wins.
  always_comb begin
    found_s = 1'b0;
    hit_s   = 1'b0;
    scan_s  = '0;
    win_s   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_s  = CH_W'((int'(rr_ptr_r) + k) % NUM_CH);
      hit_s   = ~found_s & elig_s[scan_s];
      win_s   = hit_s ? scan_s : win_s;
      found_s = found_s | hit_s;
    end
  end

  assign win_onehot_s = NUM_CH'(1) << win_s;
  assign sz_raw_s     = size_arr_s[win_s];
  assign sz_s         = (sz_raw_s > MAX_SZ) ? MAX_SZ : sz_raw_s;
  assign last_s       = IDX_W'((32'd1 << sz_s) - 32'd1);
  assign cap_idx_s    = idx_r - IDX_W'(1);
  assign next_ptr_s   = (ch_r == CH_W'(NUM_CH - 1)) ? '0 : ch_r + CH_W'(1);

  // Final read byte arrives during RTAIL and is merged before extension.
  always_comb begin
    asm_full_s = asm_r;
    asm_full_s[{last_r, 3'b000} +: 8] = bus.ram_rdata_in;
  end

  assign xfer_s            = (state_r == XFER);
  assign bus.ram_rw_out    = xfer_s & wr_r & bus.rdy_in;
  assign bus.ram_addr_out  = xfer_s ? addr_r + ADDR_W'(idx_r) : '0;
  assign bus.ram_wdata_out = (xfer_s & wr_r) ? wdata_r[{idx_r, 3'b000} +: 8] : 8'h00;
  assign bus.gnt_out       = gnt_r;
  assign bus.done_out      = done_r;
  assign bus.rdata_out     = rdata_r;

  // Transaction FSM, arbitration pointer and registered client outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r  <= IDLE;
      rr_ptr_r <= '0;
      ch_r     <= '0;
      gnt_r    <= '0;
      done_r   <= '0;
      rdata_r  <= '0;
      wr_r     <= 1'b0;
      sgn_r    <= 1'b0;
      last_r   <= '0;
      idx_r    <= '0;
      addr_r   <= '0;
      wdata_r  <= '0;
      asm_r    <= '0;
    end else if (bus.rdy_in) begin
      done_r <= '0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            ch_r    <= win_s;
            gnt_r   <= win_onehot_s;
            wr_r    <= bus.req_wr_in[win_s];
            sgn_r   <= bus.req_signed_in[win_s];
            last_r  <= last_s;
            addr_r  <= addr_arr_s[win_s];
            wdata_r <= wdata_arr_s[win_s];
            idx_r   <= '0;
            asm_r   <= '0;
            state_r <= XFER;
          end
        end
        XFER: begin
          if (!wr_r && bus.flush_in) begin
            gnt_r   <= '0;
            state_r <= IDLE;
          end else begin
            if (!wr_r && idx_r != '0) begin
              asm_r[{cap_idx_s, 3'b000} +: 8] <= bus.ram_rdata_in;
            end
            if (idx_r == last_r) begin
              if (wr_r) begin
                done_r   <= gnt_r;
                gnt_r    <= '0;
                rr_ptr_r <= next_ptr_s;
                state_r  <= IDLE;
              end else begin
                state_r  <= RTAIL;
              end
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        RTAIL: begin
          if (bus.flush_in) begin
            gnt_r   <= '0;
            state_r <= IDLE;
          end else begin
            rdata_r  <= extend_f(asm_full_s, last_r, sgn_r);
            done_r   <= gnt_r;
            gnt_r    <= '0;
            rr_ptr_r <= next_ptr_s;
            state_r  <= IDLE;
          end
        end
        default: begin
          gnt_r   <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule
